// File: rtl/arb_client_bank_if.sv
// rtl/arb_client_bank_if.sv - requester/arbiter handshake and burst transfer bus
interface arb_client_bank_if;
  logic [3:0] push;
  logic [3:0] full;
  logic [3:0] req;
  logic [3:0] grant;
  logic       xfer_valid;
  logic [1:0] xfer_id;
  logic [3:0] xfer_beat;
  logic       xfer_last;
  logic       err_grant;
  logic       ovf;

  modport slave (
    input  push, grant,
    output full, req, xfer_valid, xfer_id, xfer_beat, xfer_last, err_grant, ovf
  );

  modport master (
    output push, grant,
    input  full, req, xfer_valid, xfer_id, xfer_beat, xfer_last, err_grant, ovf
  );
endinterface

// File: rtl/arb_client_bank.sv
// rtl/arb_client_bank.sv - four-channel pending-count requester feeding a round-robin arbiter
module arb_client_bank #(
  parameter int CNT_W = 4,
  parameter int BURST = 2
) (
  input logic              clk,
  input logic              reset,
  arb_client_bank_if.slave bus
);
  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       LAST_BEAT = 4'(BURST - 1);

  state_t                  state, state_next;
  logic [3:0][CNT_W-1:0]   cnt;
  logic [3:0]              full_int;
  logic [3:0]              req_int;
  logic [3:0]              consume;
  logic [1:0]              grant_idx;
  logic                    grant_onehot;
  logic                    grant_legal;
  logic                    grant_bad;

  // The channel being transferred withdraws its request so the arbiter rotates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full_int[i] = (cnt[i] == CNT_MAX);
      req_int[i]  = (cnt[i] != '0) && !(state == XFER && bus.xfer_id == 2'(i));
    end
  end

  assign bus.full = full_int;
  assign bus.req  = req_int;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.grant[i]) grant_idx = 2'(i);
    end
  end

  assign grant_onehot = (bus.grant != 4'd0) && ((bus.grant & (bus.grant - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    grant_legal = 1'b0;
    grant_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_onehot && ((bus.grant & req_int) != 4'd0)) begin
          grant_legal = 1'b1;
          state_next  = XFER;
        end else if (bus.grant != 4'd0) begin
          grant_bad = 1'b1;
        end
      end
      XFER: begin
        if (bus.xfer_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign consume = grant_legal ? bus.grant : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.xfer_valid <= 1'b0;
      bus.xfer_id    <= '0;
      bus.xfer_beat  <= '0;
      bus.xfer_last  <= 1'b0;
      bus.err_grant  <= 1'b0;
    end else begin
      bus.err_grant <= grant_bad;
      if (grant_legal) begin
        bus.xfer_valid <= 1'b1;
        bus.xfer_id    <= grant_idx;
        bus.xfer_beat  <= '0;
        bus.xfer_last  <= (LAST_BEAT == 4'd0);
      end else if (state == XFER) begin
        if (bus.xfer_last) begin
          bus.xfer_valid <= 1'b0;
          bus.xfer_beat  <= '0;
          bus.xfer_last  <= 1'b0;
        end else begin
          bus.xfer_beat <= bus.xfer_beat + 4'd1;
          bus.xfer_last <= (bus.xfer_beat + 4'd1 == LAST_BEAT);
        end
      end
    end
  end

  // A push that coincides with a consume nets to zero and is never dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bus.ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({bus.push[i], consume[i]})
          2'b10: begin
            if (full_int[i]) bus.ovf <= 1'b1;
            else             cnt[i]  <= cnt[i] + 1'b1;
          end
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_arb_client_bank.sv
// tb/tb_arb_client_bank.sv - randomized and directed bench for arb_client_bank against a countdown model
module tb_arb_client_bank;
  localparam int BURST = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arb_client_bank_if bus ();
  arb_client_bank #(.CNT_W(4), .BURST(BURST)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Model: pending counts plus the number of beats still to be shown.
  int m_cnt [4];
  int m_left;
  int m_id;
  bit m_ovf;
  bit m_err;

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] != 0) && !(m_left > 0 && m_id == i);
    return r;
  endfunction

  task automatic step();
    logic [3:0] g, p, r;
    logic rs;
    bit legal;
    g  = bus.grant;
    p  = bus.push;
    r  = m_req();
    rs = reset;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_left = 0; m_id = 0; m_ovf = 0; m_err = 0;
    end else begin
      legal = (m_left == 0) && ($countones(g) == 1) && ((g & r) != 0);
      m_err = (m_left == 0) && (g != 0) && !legal;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (legal && g[i]) ? 1 : 0;
        if (p[i] && c == 0 && m_cnt[i] == 15) m_ovf = 1;
        else m_cnt[i] = m_cnt[i] + int'(p[i]) - c;
      end
      if (m_left > 0) m_left--;
      else if (legal) begin
        m_left = BURST;
        for (int i = 0; i < 4; i++) if (g[i]) m_id = i;
      end
    end
    #1;
    bus.push = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.push = 4'd0; bus.grant = 4'd0;
    step(); step();
    reset = 1'b0;
    checks++; if (bus.req !== 4'd0) begin errors++; $display("FAIL reset_req got=%b exp=0000", bus.req); end
    checks++; if (bus.full !== 4'd0) begin errors++; $display("FAIL reset_full got=%b exp=0000", bus.full); end
    checks++; if (bus.xfer_valid !== 1'b0 || bus.xfer_last !== 1'b0 || bus.xfer_id !== 2'd0 || bus.xfer_beat !== 4'd0)
      begin errors++; $display("FAIL reset_xfer got v=%b l=%b id=%0d b=%0d exp all 0", bus.xfer_valid, bus.xfer_last, bus.xfer_id, bus.xfer_beat); end
    checks++; if (bus.err_grant !== 1'b0 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL reset_flags got err=%b ovf=%b exp 0 0", bus.err_grant, bus.ovf); end
  endtask

  task automatic test_single();
    bus.push = 4'b0100; step();
    checks++; if (bus.req !== 4'b0100) begin errors++; $display("FAIL single_req got=%b exp=0100", bus.req); end
    bus.grant = 4'b0100; step(); bus.grant = 4'd0;
    checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_id !== 2'd2 || bus.xfer_beat !== 4'd0 || bus.xfer_last !== 1'b0)
      begin errors++; $display("FAIL single_beat0 got v=%b id=%0d b=%0d l=%b exp 1 2 0 0", bus.xfer_valid, bus.xfer_id, bus.xfer_beat, bus.xfer_last); end
    checks++; if (bus.req !== 4'd0) begin errors++; $display("FAIL single_req_burst got=%b exp=0000", bus.req); end
    step();
    checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_beat !== 4'd1 || bus.xfer_last !== 1'b1)
      begin errors++; $display("FAIL single_beat1 got v=%b b=%0d l=%b exp 1 1 1", bus.xfer_valid, bus.xfer_beat, bus.xfer_last); end
    step();
    checks++; if (bus.xfer_valid !== 1'b0 || bus.req !== 4'd0)
      begin errors++; $display("FAIL single_end got v=%b req=%b exp 0 0000", bus.xfer_valid, bus.req); end
  endtask

  task automatic test_multi();
    int ids [4] = '{0, 3, 0, 0};
    bus.push = 4'b1001; step();
    bus.push = 4'b0001; step();
    bus.push = 4'b0001; step();
    foreach (ids[k]) begin
      bus.grant = 4'(1 << ids[k]); step(); bus.grant = 4'd0;
      checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_id !== 2'(ids[k]))
        begin errors++; $display("FAIL multi_id[%0d] got v=%b id=%0d exp 1 %0d", k, bus.xfer_valid, bus.xfer_id, ids[k]); end
      if (ids[k] == 0) begin
        checks++; if (bus.req[0] !== 1'b0) begin errors++; $display("FAIL multi_req0[%0d] got=%b exp=0", k, bus.req[0]); end
      end
      repeat (BURST) step();
    end
    checks++; if (dut.cnt !== '0 || bus.req !== 4'd0)
      begin errors++; $display("FAIL multi_final got cnt=%h req=%b exp 0 0000", dut.cnt, bus.req); end
  endtask

  task automatic test_overflow();
    repeat (15) begin bus.push = 4'b0010; step(); end
    checks++; if (bus.full[1] !== 1'b1 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL ovf_full got full1=%b ovf=%b exp 1 0", bus.full[1], bus.ovf); end
    bus.push = 4'b0010; step();
    checks++; if (bus.ovf !== 1'b1 || dut.cnt[1] !== 4'd15)
      begin errors++; $display("FAIL ovf_set got ovf=%b cnt1=%0d exp 1 15", bus.ovf, dut.cnt[1]); end
  endtask

  task automatic test_reset_mid();
    bus.push = 4'b0001; step();
    bus.grant = 4'b0001; step(); bus.grant = 4'd0;
    checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_beat !== 4'd0)
      begin errors++; $display("FAIL mid_beat0 got v=%b b=%0d exp 1 0", bus.xfer_valid, bus.xfer_beat); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (bus.xfer_valid !== 1'b0 || bus.req !== 4'd0 || dut.cnt !== '0 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL mid_reset got v=%b req=%b cnt=%h ovf=%b exp 0 0000 0 0", bus.xfer_valid, bus.req, dut.cnt, bus.ovf); end
    step();
    checks++; if (bus.xfer_valid !== 1'b0) begin errors++; $display("FAIL mid_nobeat got v=%b exp 0", bus.xfer_valid); end
  endtask

  task automatic test_same_cycle();
    bus.push = 4'b0010; step();
    bus.push = 4'b0010; bus.grant = 4'b0010; step(); bus.grant = 4'd0;
    checks++; if (dut.cnt[1] !== 4'd1 || bus.xfer_valid !== 1'b1 || bus.xfer_id !== 2'd1)
      begin errors++; $display("FAIL same_cycle got cnt1=%0d v=%b id=%0d exp 1 1 1", dut.cnt[1], bus.xfer_valid, bus.xfer_id); end
    repeat (BURST) step();
    checks++; if (bus.req !== 4'b0010) begin errors++; $display("FAIL same_req got=%b exp=0010", bus.req); end
    bus.grant = 4'b0010; step(); bus.grant = 4'd0;
    repeat (BURST) step();
  endtask

  task automatic test_err();
    bus.push = 4'b0001; step();
    bus.grant = 4'b0011; step(); bus.grant = 4'd0;
    checks++; if (bus.err_grant !== 1'b1 || bus.xfer_valid !== 1'b0)
      begin errors++; $display("FAIL err_multihot got err=%b v=%b exp 1 0", bus.err_grant, bus.xfer_valid); end
    step();
    checks++; if (bus.err_grant !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b exp=0", bus.err_grant); end
    bus.grant = 4'b0100; step(); bus.grant = 4'd0;
    checks++; if (bus.err_grant !== 1'b1 || bus.xfer_valid !== 1'b0)
      begin errors++; $display("FAIL err_noreq got err=%b v=%b exp 1 0", bus.err_grant, bus.xfer_valid); end
    bus.grant = 4'b0001; step(); bus.grant = 4'd0;
    checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_id !== 2'd0 || bus.err_grant !== 1'b0)
      begin errors++; $display("FAIL err_legal got v=%b id=%0d err=%b exp 1 0 0", bus.xfer_valid, bus.xfer_id, bus.err_grant); end
    repeat (BURST) step();
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) bus.push[i] = ($urandom_range(3) == 0);
      r = m_req();
      case ($urandom_range(3))
        0, 1: bus.grant = 4'd0;
        2:    bus.grant = 4'($urandom_range(15));
        default: begin
          bus.grant = 4'd0;
          for (int i = 0; i < 4; i++) if (r[i] && bus.grant == 4'd0 && $urandom_range(1) == 1) bus.grant = 4'(1 << i);
        end
      endcase
      step();
      checks++;
      if (bus.req !== m_req() || bus.xfer_valid !== (m_left > 0) || bus.err_grant !== m_err || bus.ovf !== m_ovf
          || bus.xfer_last !== (m_left == 1)) begin
        errors++;
        $display("FAIL rand_ctl[%0d] got req=%b v=%b l=%b err=%b ovf=%b exp req=%b v=%0d l=%0d err=%0d ovf=%0d",
                 n, bus.req, bus.xfer_valid, bus.xfer_last, bus.err_grant, bus.ovf, m_req(), m_left > 0, m_left == 1, m_err, m_ovf);
      end
      if (m_left > 0) begin
        checks++;
        if (bus.xfer_id !== 2'(m_id) || bus.xfer_beat !== 4'(BURST - m_left)) begin
          errors++;
          $display("FAIL rand_beat[%0d] got id=%0d b=%0d exp id=%0d b=%0d", n, bus.xfer_id, bus.xfer_beat, m_id, BURST - m_left);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut.cnt[i] !== 4'(m_cnt[i]) || bus.full[i] !== (m_cnt[i] == 15)) begin
          errors++;
          $display("FAIL rand_cnt[%0d][%0d] got cnt=%0d full=%b exp cnt=%0d", n, i, dut.cnt[i], bus.full[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 4'd0;
    bus.grant = 4'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_left = 0; m_id = 0; m_ovf = 0; m_err = 0;
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_reset_mid();
    test_same_cycle();
    test_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
